// File: rtl/div_sequencer.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: restoring shift-subtract datapath with an IDLE/RUN/DONE FSM.
// Optional build macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
`timescale 1ns/1ps
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic [1:0]      Op,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Flush,
    output logic            Busy,
    output logic            Valid,
    output logic [XLEN-1:0] Result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            is_rem_q, is_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;

    // Operand conditioning for a request being accepted this cycle.
    logic            is_signed, sign_a, sign_b;
    logic [XLEN-1:0] abs_a, abs_b;

    always_comb begin
        is_signed = ~Op[0];
        sign_a    = is_signed & SrcA[XLEN-1];
        sign_b    = is_signed & SrcB[XLEN-1];
        abs_a     = sign_a ? -SrcA : SrcA;
        abs_b     = sign_b ? -SrcB : SrcB;
    end

    // One restoring step. The shifted remainder can need XLEN+1 bits when the divisor is large.
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] trial;
    logic            trial_ok;
    logic [XLEN-1:0] step_rem, step_quo;

    always_comb begin
        rem_sh   = {rem_q, quo_q[XLEN-1]};
        trial    = {1'b0, rem_sh} - {2'b00, div_q};
        trial_ok = ~trial[XLEN+1];
        step_rem = trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
        step_quo = {quo_q[XLEN-2:0], trial_ok};
    end

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        result_d  = result_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (Start) begin
                    is_rem_d  = Op[1];
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    div_d     = abs_b;
                    if (SrcB == '0) begin
                        result_d = Op[1] ? SrcA : '1;
                        state_d  = DONE;
                    end else if (is_signed && SrcA == MIN_NEG && SrcB == '1) begin
                        result_d = Op[1] ? '0 : MIN_NEG;
                        state_d  = DONE;
`ifdef DIV_EARLY_OUT_EN
                    end else if (abs_a < abs_b) begin
                        result_d = Op[1] ? SrcA : '0;
                        state_d  = DONE;
`endif
                    end else begin
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = abs_a;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = DONE;
                    if (is_rem_q) result_d = neg_rem_q ? -step_rem : step_rem;
                    else          result_d = neg_quo_q ? -step_quo : step_quo;
                end
            end
            default: state_d = IDLE;
        endcase

        // An aborted instruction must not disturb the architecturally visible Result.
        if (Flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            result_q  <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            result_q  <= result_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign Busy   = (state_q == RUN);
    assign Valid  = (state_q == DONE);
    assign Result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus random operands against an arithmetic reference model.
`timescale 1ns/1ps
module tb_div_sequencer;
    localparam int XLEN     = 32;
    localparam int FULL_LAT = XLEN + 1;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        reset, Start, Flush;
    logic [1:0]  Op;
    logic [31:0] SrcA, SrcB;
    logic        Busy, Valid;
    logic [31:0] Result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_result;

    always #5 clk = ~clk;

    div_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Op     (Op),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Flush  (Flush),
        .Busy   (Busy),
        .Valid  (Valid),
        .Result (Result)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model: plain integer arithmetic with RISC-V truncating division semantics.
    function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return op[1] ? r[31:0] : q[31:0];
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic longint magnitude(input logic [31:0] v, input bit signed_op);
        longint x;
        x = signed_op ? longint'($signed(v)) : longint'({32'd0, v});
        return (x < 0) ? -x : x;
    endfunction

    function automatic int model_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = !op[0];
        if (b == 32'd0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (magnitude(a, sgn) < magnitude(b, sgn)) return 1;
`endif
        return FULL_LAT;
    endfunction

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        SrcA  = a;
        SrcB  = b;
    endtask

    // Called with Start already raised in cycle 0; returns at the negedge of the Valid cycle.
    task automatic wait_result(input string tag, input logic [31:0] exp_res, input int exp_lat);
        int busy_err = 0;
        bit seen     = 1'b0;
        int lat      = 0;
        @(posedge clk);
        #1 Start = 1'b0;
        for (int c = 1; c <= FULL_LAT + 4 && !seen; c++) begin
            @(negedge clk);
            if (Valid === 1'b1) begin
                seen = 1'b1;
                lat  = c;
                if (Busy !== 1'b0) busy_err++;
            end else if (Busy !== (c < exp_lat)) begin
                busy_err++;
            end
        end
        check({tag, "/valid_seen"}, 32'(seen), 32'd1);
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/busy_profile"}, busy_err, 0);
        check({tag, "/result"}, Result, exp_res);
        last_result = exp_res;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res);
        @(posedge clk);
        #1 launch(op, a, b);
        wait_result(tag, exp_res, model_latency(op, a, b));
        @(negedge clk);
        check({tag, "/valid_one_cycle"}, 32'(Valid), 32'd0);
        check({tag, "/result_hold"}, Result, exp_res);
    endtask

    // Watches an idle DUT for some cycles; no Valid or Busy may appear and Result must hold.
    task automatic watch_idle(input string tag, input int cycles);
        int activity = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (Valid !== 1'b0 || Busy !== 1'b0) activity++;
        end
        check({tag, "/no_activity"}, activity, 0);
        check({tag, "/result"}, Result, last_result);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;

        reset = 1'b1; Start = 1'b0; Flush = 1'b0;
        Op = 2'b00; SrcA = 32'd0; SrcB = 32'd0;
        last_result = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/busy", 32'(Busy), 32'd0);
        check("reset/valid", 32'(Valid), 32'd0);
        check("reset/result", Result, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed cases with hand-derived results.
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2);
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1);
        run_op("div_5_0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_5_0",   OP_REMU, 32'd5, 32'd0, 32'd5);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("divu_3_10",  OP_DIVU, 32'd3, 32'd10, 32'd0);
        run_op("remu_3_10",  OP_REMU, 32'd3, 32'd10, 32'd3);
        run_op("divu_wide",  OP_DIVU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0);
        run_op("remu_wide",  OP_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("divu_big",   OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
        run_op("remu_big",   OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF);
        run_op("div_min_7",  OP_DIV,  32'h8000_0000, 32'd7, 32'hEDB6_DB6E);

        // Back-to-back: the second request is presented during the DONE cycle of the first.
        @(posedge clk);
        #1 launch(OP_DIVU, 32'd9, 32'd3);
        wait_result("b2b_first", 32'd3, FULL_LAT);
        launch(OP_DIVU, 32'd8, 32'd2);
        wait_result("b2b_second", 32'd4, FULL_LAT);
        @(negedge clk);
        check("b2b/valid_one_cycle", 32'(Valid), 32'd0);

        // Flush in cycle 10 of a DIVU: back to IDLE, no Valid, Result untouched.
        @(posedge clk);
        #1 launch(OP_DIVU, 32'd1000, 32'd3);
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (9) @(posedge clk);
        #1 Flush = 1'b1;
        @(negedge clk);
        check("flush/busy_before", 32'(Busy), 32'd1);
        @(posedge clk);
        #1 Flush = 1'b0;
        watch_idle("flush", FULL_LAT + 4);

        // Synchronous reset in cycle 20 of a DIVU discards it and clears Result.
        @(posedge clk);
        #1 launch(OP_DIVU, 32'd1000, 32'd3);
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        last_result = 32'd0;
        watch_idle("midrun_reset", FULL_LAT + 4);

        // Random operands with a bias toward the corner classes.
        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: begin r_a = $urandom_range(0, 50); r_b = $urandom_range(51, 1000); end
                3: r_b = r_b >> $urandom_range(1, 31);
                4: r_a = r_a >> $urandom_range(1, 31);
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, model_result(r_op, r_a, r_b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
